// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seqdet_pkg;

  // Widest pattern the helper functions can describe (MAX_LEN must not exceed this).
  localparam int unsigned SEQDET_MASK_W = 32;
  localparam int unsigned SEQDET_LEN_W  = 8;

  // Common length type wide enough for any supported pattern length.
  typedef logic [SEQDET_LEN_W-1:0] len_t;

  // A length is usable only when it selects at least one and at most max_len bits.
  function automatic logic len_valid(input len_t len, input len_t max_len);
    return (len >= len_t'(1)) && (len <= max_len);
  endfunction

  // Mask with the low 'len' bits set; callers size-cast it to their pattern width.
  function automatic logic [SEQDET_MASK_W-1:0] len_mask(input len_t len);
    logic [SEQDET_MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < SEQDET_MASK_W; i++) begin
      if (len_t'(i) < len) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating match counter with a sticky saturation flag; clear beats increment.
module seqdet_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Next count: clear has priority, otherwise step until all-ones and hold there.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      sat_d   = sat_q | (count_d == CNT_MAX);
    end else begin
      count_d = count_q;
      sat_d   = sat_q;
    end
  end

  // Counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter. Optional build macro SEQDET_MASK_EN adds a
// per-position don't-care mask (cfg_mask).
module seq_detector_prog
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
`ifdef SEQDET_MASK_EN
  input  logic [MAX_LEN-1:0]           cfg_mask,
`endif
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         count_sat
);

  localparam int LW = $clog2(MAX_LEN+1);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
`ifdef SEQDET_MASK_EN
  logic [MAX_LEN-1:0] mask_q, mask_d;
`endif
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;

  logic [MAX_LEN-1:0] hist_next_s;
  logic [LW-1:0]      fill_next_s;
  logic [MAX_LEN-1:0] cmp_mask_s;
  logic               hit_s;

  // Post-shift history/fill and the match decision for the current beat.
  always_comb begin
    hist_next_s = {hist_q[MAX_LEN-2:0], din};
    if (fill_q == LW'(MAX_LEN)) begin
      fill_next_s = fill_q;
    end else begin
      fill_next_s = fill_q + LW'(1);
    end
`ifdef SEQDET_MASK_EN
    cmp_mask_s = MAX_LEN'(len_mask(len_t'(len_q))) & ~mask_q;
`else
    cmp_mask_s = MAX_LEN'(len_mask(len_t'(len_q)));
`endif
    hit_s = din_valid
          && len_valid(len_t'(len_q), len_t'(MAX_LEN))
          && (((hist_next_s ^ pat_q) & cmp_mask_s) == '0)
          && (fill_next_s >= len_q);
  end

  // Next-state: a config load clears history and drops any coincident beat.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
`ifdef SEQDET_MASK_EN
    mask_d  = mask_q;
`endif
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
`ifdef SEQDET_MASK_EN
      mask_d  = cfg_mask;
`endif
      hist_d  = '0;
      fill_d  = '0;
      match_d = 1'b0;
    end else if (din_valid) begin
      hist_d  = hist_next_s;
      if (hit_s && !ovl_q) begin
        fill_d = '0;
      end else begin
        fill_d = fill_next_s;
      end
      match_d = hit_s;
    end else begin
      match_d = 1'b0;
    end
  end

  // Shadow config, history, fill and registered match with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
`ifdef SEQDET_MASK_EN
      mask_q  <= '0;
`endif
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
`ifdef SEQDET_MASK_EN
      mask_q  <= mask_d;
`endif
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  // Count registered match pulses.
  seqdet_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (match_q),
    .clr    (cnt_clr),
    .count  (match_count),
    .sat    (count_sat)
  );

  assign match = match_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Table-driven bench for seq_detector_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       resetn;
  logic       din, din_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_mask;
  logic       match, count_sat;
  logic [1:0] match_count;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
`ifdef SEQDET_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  typedef struct {
    int         tag;
    logic       rstn, load, clr, valid, d, ovl;
    logic [7:0] pat, mask;
    logic [3:0] len;
    logic       em;
    logic [1:0] ec;
    logic       es;
  } vec_t;

  vec_t vq[$];
  int   cur_tag = 0;
  int   nvec = 0;
  int   nerr = 0;

  // Beat/idle rows drive junk config to show it is ignored without cfg_load.
  task automatic add(input logic rstn, input logic load, input logic [7:0] pat,
                     input logic [3:0] len, input logic ovl, input logic [7:0] mask,
                     input logic clr, input logic valid, input logic d,
                     input logic em, input logic [1:0] ec, input logic es);
    vec_t v;
    v.tag = cur_tag; v.rstn = rstn; v.load = load; v.pat = pat; v.len = len;
    v.ovl = ovl; v.mask = mask; v.clr = clr; v.valid = valid; v.d = d;
    v.em = em; v.ec = ec; v.es = es;
    vq.push_back(v);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic [7:0] mask, input logic [1:0] ec, input logic es);
    add(1'b1, 1'b1, pat, len, ovl, mask, 1'b0, 1'b0, 1'b0, 1'b0, ec, es);
  endtask

  task automatic bt(input logic d, input logic em, input logic [1:0] ec, input logic es);
    add(1'b1, 1'b0, 8'hFF, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1, d, em, ec, es);
  endtask

  task automatic idl(input logic d, input logic [1:0] ec, input logic es);
    add(1'b1, 1'b0, 8'hFF, 4'd1, 1'b0, 8'h00, 1'b0, 1'b0, d, 1'b0, ec, es);
  endtask

  task automatic clr_row();
    add(1'b1, 1'b0, 8'hFF, 4'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rst_row();
    add(1'b0, 1'b0, 8'hFF, 4'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic drive(input vec_t v);
    resetn = v.rstn; cfg_load = v.load; cfg_pattern = v.pat; cfg_len = v.len;
    cfg_overlap = v.ovl; cfg_mask = v.mask; cnt_clr = v.clr;
    din_valid = v.valid; din = v.d;
  endtask

  // One hand-driven cycle, sampled 1 time unit after the edge.
  task automatic step(input logic load, input logic valid, input logic d);
    vec_t v;
    v.tag = 99; v.rstn = 1'b1; v.load = load; v.pat = 8'b0000_0110; v.len = 4'd4;
    v.ovl = 1'b1; v.mask = 8'h00; v.clr = 1'b0; v.valid = valid; v.d = d;
    v.em = 1'b0; v.ec = 2'd0; v.es = 1'b0;
    drive(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    resetn = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b0;
    cnt_clr = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_mask = 8'h00;

    // Reset state
    cur_tag = 0; rst_row(); rst_row();
    // 1: 1010 overlapping on 101010
    cur_tag = 1; cfg(8'b1010, 4'd4, 1'b1, 8'h00, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(0,1,0,0); bt(1,0,1,0); bt(0,1,1,0);
    idl(0,2,0); idl(0,2,0); clr_row();
    // 2: non-overlapping, then 1,0 more
    cur_tag = 2; cfg(8'b1010, 4'd4, 1'b0, 8'h00, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(0,1,0,0); bt(1,0,1,0); bt(0,0,1,0);
    bt(1,0,1,0); bt(0,1,1,0); idl(0,2,0); clr_row();
    // 3: gap of invalid cycles inside the pattern
    cur_tag = 3; cfg(8'b1010, 4'd4, 1'b1, 8'h00, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0);
    for (int i = 0; i < 5; i++) idl(1,0,0);
    bt(0,1,0,0); idl(0,1,0); clr_row();
    // 4: cfg_load coincident with completing beat
    cur_tag = 4; cfg(8'b1010, 4'd4, 1'b1, 8'h00, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0);
    add(1'b1, 1'b1, 8'b1010, 4'd4, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    bt(0,0,0,0); bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(0,1,0,0);
    idl(0,1,0); clr_row();
    // 5: saturation, then clear coincident with 6th match
    cur_tag = 5; cfg(8'b1010, 4'd4, 1'b1, 8'h00, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(0,1,0,0);
    bt(1,0,1,0); bt(0,1,1,0); bt(1,0,2,0); bt(0,1,2,0);
    bt(1,0,3,1); bt(0,1,3,1); bt(1,0,3,1); bt(0,1,3,1);
    bt(1,0,3,1); bt(0,1,3,1); clr_row();
    // 6: mid-stream reset
    cur_tag = 6; cfg(8'b1010, 4'd4, 1'b1, 8'h00, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(0,1,0,0); idl(0,1,0);
    cfg(8'b1010, 4'd4, 1'b1, 8'h00, 2'd1, 1'b0);
    bt(1,0,1,0); bt(0,0,1,0); bt(1,0,1,0); rst_row(); bt(0,0,0,0);
    // 7: full-length pattern
    cur_tag = 7; cfg(8'b1011_0011, 4'd8, 1'b0, 8'h00, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(1,0,0,0);
    bt(0,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(1,1,0,0); idl(0,1,0);
    // 8: one-bit pattern
    cur_tag = 8; cfg(8'h01, 4'd1, 1'b1, 8'h00, 2'd1, 1'b0);
    bt(1,1,1,0); bt(1,1,2,0); bt(0,0,3,1); bt(1,1,3,1); idl(0,3,1); clr_row();
    // 9: invalid lengths never match
    cur_tag = 9; cfg(8'h00, 4'd0, 1'b1, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) bt(0,0,0,0);
    cfg(8'h00, 4'd9, 1'b1, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 9; i++) bt(0,0,0,0);
`ifdef SEQDET_MASK_EN
    // 10: pattern 1x10
    cur_tag = 10; cfg(8'b1010, 4'd4, 1'b0, 8'b0100, 2'd0, 1'b0);
    bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(0,1,0,0);
    bt(1,0,1,0); bt(1,0,1,0); bt(1,0,1,0); bt(0,1,1,0); idl(0,2,0);
    bt(1,0,2,0); bt(0,0,2,0); bt(0,0,2,0); bt(0,0,2,0); clr_row();
`endif

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      nvec++;
      if ({match, match_count, count_sat} !== {vq[i].em, vq[i].ec, vq[i].es}) begin
        nerr++;
        $display("FAIL vec %0d (test %0d): got match=%0b count=%0d sat=%0b, want match=%0b count=%0d sat=%0b",
                 i, vq[i].tag, match, match_count, count_sat, vq[i].em, vq[i].ec, vq[i].es);
      end
    end

    // Hand sequence: 0110 pulse with a bounded wait, then width and count.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0);
    seen = match;
    for (int k = 0; k < 3 && !seen; k++) begin
      step(1'b0, 1'b0, 1'b0);
      seen = match;
    end
    nvec++;
    if (seen !== 1'b1) begin
      nerr++;
      $display("FAIL pulse_0110: got match=%0b within budget, want 1", seen);
    end
    step(1'b0, 1'b0, 1'b0);
    nvec++;
    if ({match, match_count} !== {1'b0, 2'd1}) begin
      nerr++;
      $display("FAIL pulse_width: got match=%0b count=%0d, want match=0 count=1", match, match_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
